pc_unit: RTL and testbench

- Parametrised fetch program counter: next generation of the core's PC register.
- Adds a configurable reset vector, internal sequential increment, a branch/jump redirect port with alignment checking, a parametrised halt address with a resume path, and a saturating fetch counter.
- Sits at the head of the IF stage; drives instruction-memory address and IF valid.

---
 rtl/pc_unit.sv | 142 ++++++++++++++
 tb/tb_pc_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with boot, redirect, halt/resume and saturating fetch counter
module pc_unit #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned INC          = 4,
    parameter int unsigned ALIGN_BITS   = 2,
    parameter bit          HALT_EN      = 1'b1,
    parameter logic [31:0] HALT_ADDR    = 32'd248,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             resume_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] RV_PC      = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] HALT_PC    = XLEN'(HALT_ADDR);
    localparam logic [XLEN-1:0] INC_PC     = XLEN'(INC);
    // Mask form keeps ALIGN_BITS=0 legal (no alignment requirement).
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             misaligned;
    logic             do_load;
    logic             cnt_inc;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  target_pc;

    assign misaligned = |(redirect_pc_i & ALIGN_MASK);
    assign seq_pc     = pc_q + INC_PC;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        mis_d     = mis_q;
        cnt_d     = cnt_q;
        do_load   = 1'b0;
        cnt_inc   = 1'b0;
        target_pc = seq_pc;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (valid_q && (!stall_i || (redirect_valid_i && !misaligned))) begin
                    cnt_inc = 1'b1;
                end
                if (redirect_valid_i && misaligned) begin
                    mis_d    = 1'b1;
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (HALT_EN && (pc_q == HALT_PC)) begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    if (redirect_valid_i) begin
                        do_load   = 1'b1;
                        target_pc = redirect_pc_i;
                    end else if (!stall_i) begin
                        do_load   = 1'b1;
                        target_pc = seq_pc;
                    end
                    if (do_load) begin
                        pc_d = target_pc;
                        if (HALT_EN && (target_pc == HALT_PC)) begin
                            state_d  = ST_HALT;
                            valid_d  = 1'b0;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    pc_d     = seq_pc;
                    state_d  = ST_RUN;
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                    mis_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q  <= ST_BOOT;
            pc_q     <= RV_PC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_valid_o  = valid_q;
    assign halted_o    = halted_q;
    assign misalign_o  = mis_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector bench for pc_unit (default and 8-bit wrap configurations)
module tb_pc_unit;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        resume;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        m;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic        stall_a = 1'b0;
    logic        rv_a = 1'b0;
    logic [31:0] rpc_a = '0;
    logic        resume_a = 1'b0;
    logic [31:0] pc_a;
    logic        v_a, h_a, m_a;
    logic [15:0] cnt_a;

    logic        start_b = 1'b0;
    logic        stall_b = 1'b0;
    logic        rv_b = 1'b0;
    logic [7:0]  rpc_b = '0;
    logic        resume_b = 1'b0;
    logic [7:0]  pc_b;
    logic        v_b, h_b, m_b;
    logic [1:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[28];

    pc_unit dut_a (
        .clk_i(clk), .start_i(start_a), .stall_i(stall_a),
        .redirect_valid_i(rv_a), .redirect_pc_i(rpc_a), .resume_i(resume_a),
        .pc_o(pc_a), .pc_valid_o(v_a), .halted_o(h_a), .misalign_o(m_a),
        .fetch_cnt_o(cnt_a)
    );

    pc_unit #(
        .XLEN(8), .RESET_VECTOR(32'h0000_00F8), .HALT_EN(1'b0), .CNT_W(2)
    ) dut_b (
        .clk_i(clk), .start_i(start_b), .stall_i(stall_b),
        .redirect_valid_i(rv_b), .redirect_pc_i(rpc_b), .resume_i(resume_b),
        .pc_o(pc_b), .pc_valid_o(v_b), .halted_o(h_b), .misalign_o(m_b),
        .fetch_cnt_o(cnt_b)
    );

    task automatic chk_a(input string name, input logic [31:0] pc, input logic v,
                         input logic h, input logic m, input logic [15:0] c);
        n_vec++;
        if (pc_a !== pc || v_a !== v || h_a !== h || m_a !== m || cnt_a !== c) begin
            n_err++;
            $display("FAIL %s: got pc=%h v=%b h=%b m=%b cnt=%0d, want pc=%h v=%b h=%b m=%b cnt=%0d",
                     name, pc_a, v_a, h_a, m_a, cnt_a, pc, v, h, m, c);
        end
    endtask

    task automatic chk_b(input string name, input logic [7:0] pc, input logic v,
                         input logic [1:0] c);
        n_vec++;
        if (pc_b !== pc || v_b !== v || h_b !== 1'b0 || m_b !== 1'b0 || cnt_b !== c) begin
            n_err++;
            $display("FAIL %s: got pc=%h v=%b h=%b m=%b cnt=%0d, want pc=%h v=%b h=0 m=0 cnt=%0d",
                     name, pc_b, v_b, h_b, m_b, cnt_b, pc, v, c);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            stall_a  = tbl[i].stall;
            rv_a     = tbl[i].rv;
            rpc_a    = tbl[i].rpc;
            resume_a = tbl[i].resume;
            @(posedge clk);
            #1;
            chk_a($sformatf("row%0d", i), tbl[i].pc, tbl[i].v, tbl[i].h, tbl[i].m, tbl[i].cnt);
        end
        stall_a = 1'b0; rv_a = 1'b0; rpc_a = '0; resume_a = 1'b0;
    endtask

    logic [7:0] exp_pc_b [6];
    logic [1:0] exp_cnt_b[6];

    initial begin
        //            stall rv rpc        res   pc         v  h  m  cnt
        tbl[0]  = '{0, 0, 32'h0,   0, 32'd0,    1, 0, 0, 16'd0};
        tbl[1]  = '{0, 0, 32'h0,   0, 32'd4,    1, 0, 0, 16'd1};
        tbl[2]  = '{0, 0, 32'h0,   0, 32'd8,    1, 0, 0, 16'd2};
        tbl[3]  = '{0, 0, 32'h0,   0, 32'd12,   1, 0, 0, 16'd3};
        tbl[4]  = '{0, 0, 32'h0,   0, 32'd16,   1, 0, 0, 16'd4};
        tbl[5]  = '{1, 0, 32'h0,   0, 32'd16,   1, 0, 0, 16'd4};
        tbl[6]  = '{1, 0, 32'h0,   0, 32'd16,   1, 0, 0, 16'd4};
        tbl[7]  = '{1, 0, 32'h0,   0, 32'd16,   1, 0, 0, 16'd4};
        tbl[8]  = '{1, 1, 32'h100, 0, 32'h100,  1, 0, 0, 16'd5};
        tbl[9]  = '{0, 0, 32'h0,   0, 32'h104,  1, 0, 0, 16'd6};
        tbl[10] = '{0, 1, 32'd240, 0, 32'd240,  1, 0, 0, 16'd7};
        tbl[11] = '{0, 0, 32'h0,   0, 32'd244,  1, 0, 0, 16'd8};
        tbl[12] = '{0, 0, 32'h0,   0, 32'd248,  0, 1, 0, 16'd9};
        tbl[13] = '{0, 0, 32'h0,   1, 32'd252,  1, 0, 0, 16'd9};
        tbl[14] = '{0, 0, 32'h0,   0, 32'd256,  1, 0, 0, 16'd10};
        tbl[15] = '{0, 1, 32'h102, 0, 32'd256,  0, 1, 1, 16'd11};
        tbl[16] = '{0, 0, 32'h0,   0, 32'd256,  0, 1, 1, 16'd11};
        tbl[17] = '{0, 1, 32'h200, 0, 32'd256,  0, 1, 1, 16'd11};
        tbl[18] = '{0, 0, 32'h0,   1, 32'd260,  1, 0, 0, 16'd11};
        tbl[19] = '{0, 0, 32'h0,   0, 32'd264,  1, 0, 0, 16'd12};
        tbl[20] = '{1, 1, 32'h103, 0, 32'd264,  0, 1, 1, 16'd12};
        tbl[21] = '{0, 0, 32'h0,   1, 32'd268,  1, 0, 0, 16'd12};
        tbl[22] = '{0, 1, 32'd36,  0, 32'd36,   1, 0, 0, 16'd13};
        tbl[23] = '{0, 0, 32'h0,   0, 32'd40,   1, 0, 0, 16'd14};
        tbl[24] = '{1, 1, 32'h103, 1, 32'd0,    1, 0, 0, 16'd0};
        tbl[25] = '{0, 1, 32'd248, 0, 32'd248,  0, 1, 0, 16'd1};
        tbl[26] = '{0, 0, 32'h0,   1, 32'd252,  1, 0, 0, 16'd1};
        tbl[27] = '{0, 0, 32'h0,   0, 32'd256,  1, 0, 0, 16'd2};

        exp_pc_b[0] = 8'hF8; exp_cnt_b[0] = 2'd0;
        exp_pc_b[1] = 8'hFC; exp_cnt_b[1] = 2'd1;
        exp_pc_b[2] = 8'h00; exp_cnt_b[2] = 2'd2;
        exp_pc_b[3] = 8'h04; exp_cnt_b[3] = 2'd3;
        exp_pc_b[4] = 8'h08; exp_cnt_b[4] = 2'd3;
        exp_pc_b[5] = 8'h0C; exp_cnt_b[5] = 2'd3;

        repeat (2) @(posedge clk);
        #1;
        chk_a("reset_a", 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        @(negedge clk);
        start_a = 1'b1;
        run_rows(0, 12);

        // Parked at the halt address: redirects and stalls must not move it.
        for (int i = 0; i < 10; i++) begin
            stall_a = i[0];
            rv_a    = 1'b1;
            rpc_a   = 32'h40;
            @(posedge clk);
            #1;
            chk_a($sformatf("halt_hold%0d", i), 32'd248, 1'b0, 1'b1, 1'b0, 16'd9);
        end

        run_rows(13, 23);

        // Asynchronous reset between edges while running at pc 40.
        @(negedge clk);
        start_a = 1'b0;
        #1;
        chk_a("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        start_a = 1'b1;
        run_rows(24, 27);

        #1;
        chk_b("reset_b", 8'hF8, 1'b0, 2'd0);
        @(negedge clk);
        start_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk_b($sformatf("wrap%0d", i), exp_pc_b[i], 1'b1, exp_cnt_b[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
